uart_tx_engine: RTL

//  Parametrised UART transmit engine: holding register, shifter, bit counter, parity and frame FSM in one block.

---
 rtl/uart_tx_engine.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: holding register, shifter, bit counter, parity and frame FSM.
// Bit timing comes from a one-cycle baud tick; the hold-register handshake follows clk.
module uart_tx_engine #(
    parameter  int MAX_DATA_BITS = 9,
    localparam int CW            = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_clk_en,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [CW-1:0]            data_bits,
    input  logic [2:0]               parity_mode,
    input  logic                     stop_bits,
    input  logic                     break_req,
    output logic                     txd,
    output logic                     busy,
    output logic                     frame_done
);

    localparam logic [CW-1:0] C_MIN_BITS = CW'(5);
    localparam logic [CW-1:0] C_MAX_BITS = CW'(MAX_DATA_BITS);

    localparam logic [2:0] P_NONE  = 3'd0;
    localparam logic [2:0] P_ODD   = 3'd1;
    localparam logic [2:0] P_EVEN  = 3'd2;
    localparam logic [2:0] P_MARK  = 3'd3;
    localparam logic [2:0] P_SPACE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BREAK,
        S_BREAK_MARK
    } state_t;

    state_t                   r_state;
    logic                     r_txd;
    logic                     r_frame_done;

    logic                     r_hold_full;
    logic [MAX_DATA_BITS-1:0] r_hold_data;
    logic [CW-1:0]            r_hold_nbits;
    logic [2:0]               r_hold_par;
    logic                     r_hold_stop2;

    logic [MAX_DATA_BITS-1:0] r_shift;
    logic [CW-1:0]            r_nbits;
    logic [2:0]               r_par;
    logic                     r_stop2;
    logic                     r_par_acc;
    logic [CW-1:0]            r_cnt;

    logic [CW-1:0]            w_nbits;
    logic [2:0]               w_par_mode;
    logic [MAX_DATA_BITS-1:0] w_data_masked;
    logic                     w_accept;
    logic                     w_eof;
    logic                     w_load;
    logic                     w_acc_final;
    logic                     w_par_bit;

    always_comb begin
        w_nbits = data_bits;
        if (data_bits < C_MIN_BITS) begin
            w_nbits = C_MIN_BITS;
        end else if (data_bits > C_MAX_BITS) begin
            w_nbits = C_MAX_BITS;
        end
    end

    // Reserved parity codes collapse to "none" at capture so the FSM only sees five modes.
    assign w_par_mode = (parity_mode <= P_SPACE) ? parity_mode : P_NONE;

    generate
        for (genvar gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_mask
            assign w_data_masked[gi] = tx_data[gi] & (CW'(gi) < w_nbits);
        end
    endgenerate

    assign w_accept = tx_valid && !r_hold_full;
    assign w_eof    = tx_clk_en && ((r_state == S_STOP1 && !r_stop2) || r_state == S_STOP2);
    assign w_load   = tx_clk_en && r_hold_full && !break_req && ((r_state == S_IDLE) || w_eof);

    // Parity covers the bit on the line during the final DATA period as well.
    assign w_acc_final = r_par_acc ^ r_shift[0];

    always_comb begin
        case (r_par)
            P_ODD:   w_par_bit = ~w_acc_final;
            P_EVEN:  w_par_bit = w_acc_final;
            P_MARK:  w_par_bit = 1'b1;
            P_SPACE: w_par_bit = 1'b0;
            default: w_par_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_txd        <= 1'b1;
            r_frame_done <= 1'b0;
            r_hold_full  <= 1'b0;
            r_hold_data  <= '0;
            r_hold_nbits <= C_MIN_BITS;
            r_hold_par   <= P_NONE;
            r_hold_stop2 <= 1'b0;
            r_shift      <= '0;
            r_nbits      <= C_MIN_BITS;
            r_par        <= P_NONE;
            r_stop2      <= 1'b0;
            r_par_acc    <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_accept) begin
                r_hold_full  <= 1'b1;
                r_hold_data  <= w_data_masked;
                r_hold_nbits <= w_nbits;
                r_hold_par   <= w_par_mode;
                r_hold_stop2 <= stop_bits;
            end

            // Loading requires hold_full while accepting requires !hold_full, so they never collide.
            if (w_load) begin
                r_hold_full <= 1'b0;
                r_shift     <= r_hold_data;
                r_nbits     <= r_hold_nbits;
                r_par       <= r_hold_par;
                r_stop2     <= r_hold_stop2;
                r_par_acc   <= 1'b0;
            end

            if (tx_clk_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (break_req) begin
                            r_state <= S_BREAK;
                            r_txd   <= 1'b0;
                        end else if (r_hold_full) begin
                            r_state <= S_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_txd   <= 1'b1;
                        end
                    end
                    S_START: begin
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                        r_cnt   <= '0;
                    end
                    S_DATA: begin
                        r_par_acc <= w_acc_final;
                        if (r_cnt == r_nbits - CW'(1)) begin
                            if (r_par != P_NONE) begin
                                r_state <= S_PARITY;
                                r_txd   <= w_par_bit;
                            end else begin
                                r_state <= S_STOP1;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_txd   <= r_shift[1];
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP1;
                        r_txd   <= 1'b1;
                    end
                    S_STOP1, S_STOP2: begin
                        if (r_state == S_STOP1 && r_stop2) begin
                            r_state <= S_STOP2;
                            r_txd   <= 1'b1;
                        end else begin
                            r_frame_done <= 1'b1;
                            if (break_req) begin
                                r_state <= S_BREAK;
                                r_txd   <= 1'b0;
                            end else if (r_hold_full) begin
                                r_state <= S_START;
                                r_txd   <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_txd   <= 1'b1;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (break_req) begin
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= S_BREAK_MARK;
                            r_txd   <= 1'b1;
                        end
                    end
                    S_BREAK_MARK: begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_ready   = !r_hold_full;
    assign busy       = (r_state != S_IDLE) || r_hold_full;
    assign txd        = r_txd;
    assign frame_done = r_frame_done;

endmodule
